fib_stack_ctrl: RTL and testbench

FIB_STACK_CTRL -- requirements
Module: fib_stack_ctrl

---
 rtl/fib_stack_ctrl_if.sv | 13 +
 rtl/fib_stack_ctrl.sv | 113 +++++++++++
 tb/tb_fib_stack_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_stack_ctrl_if.sv
// Stack bus between fib_stack_ctrl (master) and an external Stack (slave).
//   stk_push / stk_pop : one-cycle operation strobes, never both high
//   stk_din            : value to push, 0 when not pushing
//   stk_dout           : current top of stack, combinational from the Stack
interface fib_stack_ctrl_if #(parameter int WIDTH = 8);
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;

  modport master (output stk_push, stk_pop, stk_din, input stk_dout);
  modport slave  (input stk_push, stk_pop, stk_din, output stk_dout);
endinterface

// File: rtl/fib_stack_ctrl.sv
// Recursive Fibonacci evaluated with an external stack: push n, then pop x;
// leaves (x<2) accumulate into acc, internal nodes push x-1 and x-2. The run
// ends when the locally tracked depth returns to 0.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start, n     : request fib(n); sampled in IDLE only
//   busy         : high in every state but IDLE
//   done         : one-cycle pulse, result valid in the same cycle
//   result       : fib(n) mod 2^WIDTH, held until the next accepted start
//   ovf          : sticky depth-limit error, cleared by next start or rst
//   stk          : stack bus (master side)
module fib_stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  fib_stack_ctrl_if.master stk
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0]    DMAX = DW'(DEPTH);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  typedef enum logic [2:0] {IDLE, PUSH_N, POP, PUSH_A, PUSH_B, DONE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       n_q;
  logic [WIDTH-1:0] x_q, x_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [DW-1:0]    depth, depth_nxt;
  logic             ovf_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_q    <= '0;
      x_q    <= '0;
      acc    <= '0;
      depth  <= '0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      acc   <= acc_nxt;
      depth <= depth_nxt;
      ovf   <= ovf_nxt;
      if (state == IDLE && start) n_q <= n;
      // Only the run-ending transitions lead to DONE, so result is written
      // exactly once per run and is already valid while done is high.
      if (state_nxt == DONE) result <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    x_nxt        = x_q;
    acc_nxt      = acc;
    depth_nxt    = depth;
    ovf_nxt      = ovf;
    stk.stk_push = 1'b0;
    stk.stk_pop  = 1'b0;
    stk.stk_din  = '0;
    case (state)
      IDLE: if (start) begin
        state_nxt = PUSH_N;
        acc_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
      PUSH_N: begin
        stk.stk_push = 1'b1;
        stk.stk_din  = WIDTH'(n_q);
        depth_nxt    = DW'(1);
        state_nxt    = POP;
      end
      POP: begin
        stk.stk_pop = 1'b1;
        x_nxt       = stk.stk_dout;
        depth_nxt   = depth - DW'(1);
        if (stk.stk_dout < TWO) begin
          acc_nxt   = acc + stk.stk_dout;
          state_nxt = (depth_nxt != '0) ? POP : DONE;
        end else begin
          state_nxt = PUSH_A;
        end
      end
      PUSH_A, PUSH_B: begin
        // A full stack aborts the run with the partial sum rather than
        // letting the wrapping Stack pointer overwrite live entries.
        if (depth == DMAX) begin
          ovf_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          stk.stk_push = 1'b1;
          stk.stk_din  = (state == PUSH_A) ? x_q - WIDTH'(1) : x_q - TWO;
          depth_nxt    = depth + DW'(1);
          state_nxt    = (state == PUSH_A) ? PUSH_B : POP;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_fib_stack_ctrl.sv
module tb_fib_stack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default DEPTH=32
  logic       start = 1'b0;
  logic [4:0] n = '0;
  logic       busy, done, ovf;
  logic [7:0] result;
  fib_stack_ctrl_if #(.WIDTH(8)) sif ();

  fib_stack_ctrl #(.WIDTH(8), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .busy(busy), .done(done),
    .result(result), .ovf(ovf), .stk(sif.master));

  // Instance B: DEPTH=4 for the depth-limit scenario
  logic       start4 = 1'b0;
  logic [4:0] n4 = '0;
  logic       busy4, done4, ovf4;
  logic [7:0] result4;
  fib_stack_ctrl_if #(.WIDTH(8)) sif4 ();

  fib_stack_ctrl #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .n(n4), .busy(busy4), .done(done4),
    .result(result4), .ovf(ovf4), .stk(sif4.master));

  // Behavioural stacks: pointer wraps modulo DEPTH, never reset.
  logic [7:0] mem [32];
  logic [4:0] sp = '0;
  logic [7:0] mem4 [4];
  logic [1:0] sp4 = '0;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem4[i] = '0;
  end
  assign sif.stk_dout  = mem[sp - 5'd1];
  assign sif4.stk_dout = mem4[sp4 - 2'd1];
  always @(posedge clk) begin
    if (sif.stk_push) begin mem[sp] <= sif.stk_din; sp <= sp + 5'd1; end
    else if (sif.stk_pop) sp <= sp - 5'd1;
    if (sif4.stk_push) begin mem4[sp4] <= sif4.stk_din; sp4 <= sp4 + 2'd1; end
    else if (sif4.stk_pop) sp4 <= sp4 - 2'd1;
  end

  int tests = 0;
  int fails = 0;
  int both_viol = 0;
  int din_viol = 0;
  int done_cnt = 0;
  bit log_en = 1'b0;
  logic [15:0] oplog [$];

  always @(negedge clk) begin
    if (sif.stk_push && sif.stk_pop) both_viol++;
    if (sif4.stk_push && sif4.stk_pop) both_viol++;
    if (!sif.stk_push && sif.stk_din != 8'd0) din_viol++;
    if (!sif4.stk_push && sif4.stk_din != 8'd0) din_viol++;
    if (done) done_cnt++;
    if (log_en) begin
      if (sif.stk_push) oplog.push_back({8'h01, sif.stk_din});
      else if (sif.stk_pop) oplog.push_back(16'h0200);
    end
  end

  // Starts a run on instance A (sel=0) or B (sel=1) and waits for done.
  // cyc counts negedges after the accepted start edge up to the done cycle.
  task automatic do_run(input bit sel, input logic [4:0] nn, output int cyc,
                        output logic [7:0] res, output logic ov);
    bit d;
    @(negedge clk);
    if (sel) begin start4 = 1'b1; n4 = nn; end
    else begin start = 1'b1; n = nn; end
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    n = 5'($urandom); n4 = 5'($urandom);
    cyc = 1;
    d = sel ? done4 : done;
    while (!d && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      d = sel ? done4 : done;
    end
    tests++;
    if (!d) begin
      fails++;
      $display("FAIL run_timeout n=%0d: no done after %0d cycles", nn, cyc);
    end
    res = sel ? result4 : result;
    ov  = sel ? ovf4 : ovf;
    @(negedge clk);
    tests++;
    if ((sel ? done4 : done) !== 1'b0 || (sel ? busy4 : busy) !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse n=%0d: done=%b busy=%b, want 0 0", nn,
               sel ? done4 : done, sel ? busy4 : busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, result, ovf, sif.stk_push, sif.stk_pop, sif.stk_din} !== 20'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d ovf=%b push=%b pop=%b din=%0d, want all 0",
               busy, done, result, ovf, sif.stk_push, sif.stk_pop, sif.stk_din);
    end
    rst = 1'b0;
  endtask

  task automatic test_small;
    int c; logic [7:0] r; logic o;
    do_run(1'b0, 5'd0, c, r, o);
    tests++;
    if (c !== 3 || r !== 8'd0 || o !== 1'b0) begin
      fails++;
      $display("FAIL fib0: cyc=%0d result=%0d ovf=%b, want 3 0 0", c, r, o);
    end
    do_run(1'b0, 5'd1, c, r, o);
    tests++;
    if (c !== 3 || r !== 8'd1 || o !== 1'b0) begin
      fails++;
      $display("FAIL fib1: cyc=%0d result=%0d ovf=%b, want 3 1 0", c, r, o);
    end
  endtask

  task automatic test_n2_sequence;
    int c; logic [7:0] r; logic o;
    logic [15:0] exp_ops [6];
    exp_ops = '{16'h0102, 16'h0200, 16'h0101, 16'h0100, 16'h0200, 16'h0200};
    oplog.delete();
    log_en = 1'b1;
    do_run(1'b0, 5'd2, c, r, o);
    log_en = 1'b0;
    tests++;
    if (c !== 7 || r !== 8'd1) begin
      fails++;
      $display("FAIL fib2: cyc=%0d result=%0d, want 7 1", c, r);
    end
    tests++;
    if (oplog.size() != 6) begin
      fails++;
      $display("FAIL fib2_ops_len: got %0d ops, want 6", oplog.size());
    end else begin
      for (int i = 0; i < 6; i++)
        if (oplog[i] !== exp_ops[i]) begin
          fails++;
          $display("FAIL fib2_op%0d: got %h, want %h", i, oplog[i], exp_ops[i]);
          break;
        end
    end
  endtask

  task automatic test_large;
    int c; logic [7:0] r; logic o;
    do_run(1'b0, 5'd13, c, r, o);
    tests++;
    if (r !== 8'd233 || o !== 1'b0) begin
      fails++;
      $display("FAIL fib13: result=%0d ovf=%b, want 233 0", r, o);
    end
    do_run(1'b0, 5'd14, c, r, o);
    tests++;
    if (r !== 8'd121 || o !== 1'b0) begin
      fails++;
      $display("FAIL fib14_wrap: result=%0d ovf=%b, want 121 0", r, o);
    end
    tests++;
    if (both_viol != 0 || din_viol != 0) begin
      fails++;
      $display("FAIL stack_strobes: push&pop cycles=%0d, din!=0 idle cycles=%0d, want 0 0",
               both_viol, din_viol);
    end
  endtask

  task automatic test_start_held;
    int d0, cyc, idle_mid;
    logic [7:0] r;
    @(negedge clk);
    start = 1'b1; n = 5'd5;
    d0 = done_cnt;
    cyc = 0; idle_mid = 0;
    r = '0;
    do begin
      @(negedge clk);
      cyc++;
      n = 5'($urandom);
      if (!busy) idle_mid++;
      if (done) begin r = result; start = 1'b0; end
    end while (start && cyc < 2000);
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || r !== 8'd5) begin
      fails++;
      $display("FAIL start_held: dones=%0d result=%0d, want 1 5", done_cnt - d0, r);
    end
    tests++;
    if (idle_mid != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_held_busy: idle cycles in run=%0d busy_after=%b, want 0 0",
               idle_mid, busy);
    end
  endtask

  task automatic test_mid_reset;
    int c; logic [7:0] r; logic o;
    @(negedge clk);
    start = 1'b1; n = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_busy: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, result, ovf, sif.stk_push, sif.stk_pop} !== 12'd0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b done=%b result=%0d ovf=%b push=%b pop=%b, want all 0",
               busy, done, result, ovf, sif.stk_push, sif.stk_pop);
    end
    rst = 1'b0;
    do_run(1'b0, 5'd6, c, r, o);
    tests++;
    if (r !== 8'd8 || o !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_fib6: result=%0d ovf=%b, want 8 0", r, o);
    end
  endtask

  task automatic test_ovf;
    int c; logic [7:0] r; logic o;
    do_run(1'b1, 5'd8, c, r, o);
    tests++;
    // Pops of 8,6,4,2 are all internal nodes, so the partial sum is 0.
    if (o !== 1'b1 || r !== 8'd0) begin
      fails++;
      $display("FAIL depth_ovf: ovf=%b result=%0d, want 1 0", o, r);
    end
    tests++;
    if (ovf4 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b, want 1", ovf4);
    end
    do_run(1'b1, 5'd3, c, r, o);
    tests++;
    if (o !== 1'b0 || r !== 8'd2) begin
      fails++;
      $display("FAIL ovf_clear_fib3: ovf=%b result=%0d, want 0 2", o, r);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_n2_sequence();
    test_large();
    test_start_held();
    test_mid_reset();
    test_ovf();
    tests++;
    if (both_viol != 0 || din_viol != 0) begin
      fails++;
      $display("FAIL strobes_final: push&pop=%0d din_idle=%0d, want 0 0", both_viol, din_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
